// File: rtl/count_down_to_zero.sv
// Datapath primitives for the NeoPixel controller: loadable down-counter, one-hot decoder, 8:1 mux.
// Optional macro CDZ_WRAP_EN makes the counter wrap from 0 to all-ones instead of saturating.

module count_down_to_zero #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] Q,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_zero;

  assign at_zero = (count_q == '0);

  // Load wins over enable; the zero case either saturates or wraps depending on the build.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = D;
    end else if (en) begin
`ifdef CDZ_WRAP_EN
      count_d = count_q - 1'b1;
`else
      if (!at_zero) begin
        count_d = count_q - 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q    = count_q;
  assign done = at_zero;

endmodule

module decoder #(
  parameter int WIDTH = 8,
  parameter int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [SEL_W-1:0] I,
  input  logic             en,
  output logic [WIDTH-1:0] D
);

  // Indices past WIDTH-1 match no output bit, so D stays all-zero for them.
  always_comb begin
    D = '0;
    for (int i = 0; i < WIDTH; i++) begin
      D[i] = en && (int'(I) == i);
    end
  end

endmodule

module mux8to1 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic [WIDTH-1:0] I2,
  input  logic [WIDTH-1:0] I3,
  input  logic [WIDTH-1:0] I4,
  input  logic [WIDTH-1:0] I5,
  input  logic [WIDTH-1:0] I6,
  input  logic [WIDTH-1:0] I7,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] Y
);

  // An unknown select falls through to the default and propagates as X.
  always_comb begin
    Y = 'x;
    case (S)
      3'd0: Y = I0;
      3'd1: Y = I1;
      3'd2: Y = I2;
      3'd3: Y = I3;
      3'd4: Y = I4;
      3'd5: Y = I5;
      3'd6: Y = I6;
      3'd7: Y = I7;
      default: Y = 'x;
    endcase
  end

endmodule

// File: tb/tb_count_down_to_zero.sv
// Directed self-checking bench for count_down_to_zero (8- and 12-bit), decoder and mux8to1.
// Expectations follow the CDZ_WRAP_EN build setting.

module tb_count_down_to_zero;

  logic clock;
  logic reset;

  logic [7:0]  d8;
  logic        load8;
  logic        en8;
  logic [7:0]  q8;
  logic        done8;

  logic [11:0] d12;
  logic        load12;
  logic        en12;
  logic [11:0] q12;
  logic        done12;

  logic [2:0]  dec_i;
  logic        dec_en;
  logic [7:0]  dec_d;
  logic [2:0]  dec5_i;
  logic [4:0]  dec5_d;

  logic [11:0] mux_in [8];
  logic [2:0]  mux_s;
  logic [11:0] mux_y;

  int num_checks;
  int num_fails;

  count_down_to_zero #(.WIDTH(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .D     (d8),
    .load  (load8),
    .en    (en8),
    .Q     (q8),
    .done  (done8)
  );

  count_down_to_zero #(.WIDTH(12)) dut12 (
    .clock (clock),
    .reset (reset),
    .D     (d12),
    .load  (load12),
    .en    (en12),
    .Q     (q12),
    .done  (done12)
  );

  decoder #(.WIDTH(8)) dec8 (
    .I  (dec_i),
    .en (dec_en),
    .D  (dec_d)
  );

  decoder #(.WIDTH(5)) dec5 (
    .I  (dec5_i),
    .en (dec_en),
    .D  (dec5_d)
  );

  mux8to1 #(.WIDTH(12)) mux (
    .I0 (mux_in[0]),
    .I1 (mux_in[1]),
    .I2 (mux_in[2]),
    .I3 (mux_in[3]),
    .I4 (mux_in[4]),
    .I5 (mux_in[5]),
    .I6 (mux_in[6]),
    .I7 (mux_in[7]),
    .S  (mux_s),
    .Y  (mux_y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    assert (observed === expected)
    else begin
      num_fails++;
      $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)",
             tag, observed, observed, expected, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    num_checks = 0;
    num_fails  = 0;
    reset  = 1'b1;
    d8 = '0;  load8 = 1'b0;  en8 = 1'b0;
    d12 = '0; load12 = 1'b0; en12 = 1'b0;
    dec_i = '0; dec5_i = '0; dec_en = 1'b0;
    mux_s = '0;
    for (int i = 0; i < 8; i++) mux_in[i] = '0;

    #12;
    check("reset_q8", 32'(q8), 32'd0);
    check("reset_done8", 32'(done8), 32'd1);
    check("reset_q12", 32'(q12), 32'd0);
    reset = 1'b0;

    // load 9, count a little, then async reset mid-count with load=1 D=5
    d8 = 8'd9; load8 = 1'b1; en8 = 1'b0;
    step();
    check("load9_q", 32'(q8), 32'd9);
    check("load9_done", 32'(done8), 32'd0);
    load8 = 1'b0; en8 = 1'b1;
    step();
    step();
    check("dec2_q", 32'(q8), 32'd7);
    #2;
    load8 = 1'b1; d8 = 8'd5; reset = 1'b1;
    #1;
    check("async_reset_q", 32'(q8), 32'd0);
    check("async_reset_done", 32'(done8), 32'd1);
    step();
    step();
    check("reset_hold_q", 32'(q8), 32'd0);
    reset = 1'b0;

    // load vs enable priority
    load8 = 1'b1; en8 = 1'b0; d8 = 8'd7;
    step();
    check("load7_q", 32'(q8), 32'd7);
    load8 = 1'b1; en8 = 1'b1; d8 = 8'd192;
    step();
    check("load_prio_q", 32'(q8), 32'd192);
    load8 = 1'b0; en8 = 1'b0;
    repeat (10) step();
    check("hold10_q", 32'(q8), 32'd192);
    en8 = 1'b1;
    step();
    check("dec_once_q", 32'(q8), 32'd191);

    // load of zero, then enable at zero
    load8 = 1'b1; en8 = 1'b0; d8 = 8'd0;
    step();
    check("load0_q", 32'(q8), 32'd0);
    check("load0_done", 32'(done8), 32'd1);
    load8 = 1'b0; en8 = 1'b1;
    step();
`ifdef CDZ_WRAP_EN
    check("zero_en_q", 32'(q8), 32'hFF);
    check("zero_en_done", 32'(done8), 32'd0);
`else
    check("zero_en_q", 32'(q8), 32'd0);
    check("zero_en_done", 32'(done8), 32'd1);
`endif
    en8 = 1'b0;

    // 12-bit timer: load 2500, done exactly 2500 edges later
    load12 = 1'b1; en12 = 1'b1; d12 = 12'd2500;
    step();
    check("load2500_q", 32'(q12), 32'd2500);
    load12 = 1'b0;
    repeat (2499) step();
    check("t2499_q", 32'(q12), 32'd1);
    check("t2499_done", 32'(done12), 32'd0);
    step();
    check("t2500_q", 32'(q12), 32'd0);
    check("t2500_done", 32'(done12), 32'd1);
    step();
`ifdef CDZ_WRAP_EN
    check("t2501_q", 32'(q12), 32'hFFF);
    check("t2501_done", 32'(done12), 32'd0);
`else
    step();
    check("t2502_q", 32'(q12), 32'd0);
    check("t2502_done", 32'(done12), 32'd1);
`endif
    en12 = 1'b0;

    // decoder sweep
    dec_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dec_i = 3'(i);
      #1;
      check("dec_onehot", 32'(dec_d), 32'd1 << i);
    end
    dec_en = 1'b0; dec_i = 3'd3;
    #1;
    check("dec_disabled", 32'(dec_d), 32'd0);
    dec_en = 1'b1; dec5_i = 3'd4;
    #1;
    check("dec5_i4", 32'(dec5_d), 32'h10);
    dec5_i = 3'd6;
    #1;
    check("dec5_out_of_range", 32'(dec5_d), 32'd0);

    // mux selection
    mux_in[0] = 12'd35;  mux_in[1] = 12'd30; mux_in[2] = 12'd18;
    mux_in[3] = 12'd40;  mux_in[4] = 12'd2500;
    mux_in[5] = 12'd5;   mux_in[6] = 12'd6;  mux_in[7] = 12'd4095;
    mux_s = 3'd0; #1; check("mux_s0", 32'(mux_y), 32'd35);
    mux_s = 3'd1; #1; check("mux_s1", 32'(mux_y), 32'd30);
    mux_s = 3'd2; #1; check("mux_s2", 32'(mux_y), 32'd18);
    mux_s = 3'd3; #1; check("mux_s3", 32'(mux_y), 32'd40);
    mux_s = 3'd4; #1; check("mux_s4", 32'(mux_y), 32'd2500);
    mux_s = 3'd7; #1; check("mux_s7", 32'(mux_y), 32'd4095);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
